block_padder: RTL

- Upstream stage of the integrated AEAD wrapper. Packs a 32-bit word stream into 128-bit blocks and writes them into the wrapper's data or text FIFO.
- Applies 10* padding: a 0x80 byte goes directly after the last message byte, followed by zeros. If the message fills the final block exactly, one extra block 0x80000000_00000000_00000000_00000000 is emitted.
- One instance is used per FIFO: associated data and plaintext/ciphertext.

---
 rtl/block_padder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/block_padder.sv
// block_padder: packs 32-bit words into 128-bit blocks with 10* padding.
// Latency: block written the cycle after the completing word is accepted.
// Backpressure: fifo_full stalls EMIT/PAD indefinitely; in_ready low until written.
// Optional: define PADDER_BLKCNT_EN to build the blk_count counter (else tied 0).
module block_padder #(
  parameter int WORD_W = 32,
  parameter int BLK_W  = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [2:0]        in_bytes,
  output logic              in_ready,
  input  logic              fifo_full,
  output logic [BLK_W-1:0]  blk_data,
  output logic              blk_wr_en,
  output logic              msg_done,
  output logic              busy,
  output logic [CNT_W-1:0]  blk_count
);

  localparam int WORDS = BLK_W / WORD_W;
  localparam int IDX_W = $clog2(WORDS);

  // Padding marker: a 0x80 byte in the first byte position, zeros after it.
  localparam logic [WORD_W-1:0] PAD_WORD = {1'b1, {(WORD_W-1){1'b0}}};
  localparam logic [BLK_W-1:0]  PAD_BLK  = {1'b1, {(BLK_W-1){1'b0}}};

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    PAD  = 2'd2
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx_q;
  logic [BLK_W-1:0]  hold_q;
  logic [BLK_W-1:0]  hold_nxt;
  logic              fin_q;   // the block in EMIT closes the message
  logic              pad_q;   // message ended on a block boundary, extra pad block owed
  logic              busy_q;
  logic [2:0]        nbytes;
  logic [WORD_W-1:0] last_word;
  logic              accept;
  logic              wr_fire;
  logic              full_last;

  // Gating with reset keeps in_ready low while reset is held.
  assign in_ready  = reset && (state == FILL);
  assign accept    = in_valid && in_ready;
  assign blk_wr_en = (state == EMIT || state == PAD) && !fifo_full;
  assign wr_fire   = blk_wr_en;
  assign blk_data  = (state == PAD) ? PAD_BLK : hold_q;
  assign busy      = busy_q;

  // Completion is decoded from registered flags so it lines up with the write it marks.
  assign msg_done  = wr_fire && ((state == PAD) || (state == EMIT && fin_q && !pad_q));

  // A full last word in the final slot leaves no room for the marker.
  assign full_last = (nbytes == 3'd4) && (idx_q == IDX_W'(WORDS - 1));

  // Saturate the valid-byte count and build the padded final word.
  always_comb begin
    nbytes = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    last_word = in_data;
    case (nbytes)
      3'd0:    last_word = PAD_WORD;
      3'd1:    last_word = {in_data[31:24], 24'h80_0000};
      3'd2:    last_word = {in_data[31:16], 16'h8000};
      3'd3:    last_word = {in_data[31:8], 8'h80};
      default: last_word = in_data;
    endcase
  end

  // Next holding register: write the current slot, zero/mark later slots on the last word.
  always_comb begin
    hold_nxt = hold_q;
    for (int s = 0; s < WORDS; s++) begin
      if (s == int'(idx_q)) begin
        hold_nxt[BLK_W-1-WORD_W*s -: WORD_W] = in_last ? last_word : in_data;
      end else if (in_last && (s > int'(idx_q))) begin
        if ((nbytes == 3'd4) && (s == int'(idx_q) + 1)) begin
          hold_nxt[BLK_W-1-WORD_W*s -: WORD_W] = PAD_WORD;
        end else begin
          hold_nxt[BLK_W-1-WORD_W*s -: WORD_W] = '0;
        end
      end
    end
  end

  // Main FSM: fill slots, emit the block, optionally emit the extra pad block.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= FILL;
      idx_q  <= '0;
      hold_q <= '0;
      fin_q  <= 1'b0;
      pad_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            hold_q <= hold_nxt;
            idx_q  <= idx_q + 1'b1;
            busy_q <= 1'b1;
            if (in_last) begin
              fin_q <= !full_last;
              pad_q <= full_last;
              state <= EMIT;
            end else if (idx_q == IDX_W'(WORDS - 1)) begin
              state <= EMIT;
            end
          end
        end
        EMIT: begin
          if (wr_fire) begin
            idx_q <= '0;
            if (pad_q) begin
              state <= PAD;
            end else begin
              if (fin_q) begin
                busy_q <= 1'b0;
              end
              fin_q <= 1'b0;
              state <= FILL;
            end
          end
        end
        PAD: begin
          if (wr_fire) begin
            pad_q  <= 1'b0;
            busy_q <= 1'b0;
            state  <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef PADDER_BLKCNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Block counter: restarts on the first word of a message, holds after completion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (accept && !busy_q) begin
      cnt_q <= '0;
    end else if (wr_fire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign blk_count = cnt_q;
`else
  assign blk_count = '0;
`endif

endmodule
